// File: rtl/dram_sram_resp_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : dram_sram_resp_if
// Desc   : Data RAM request/response bundle between the core and its memory.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface dram_sram_resp_if;
  logic        dram_req;
  logic        dram_write;
  logic [3:0]  dram_wstrb;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_ready;
  logic [31:0] dram_rdata;
  logic        dram_rvalid;
  logic        dram_err;

  modport master (
    output dram_req, dram_write, dram_wstrb, dram_addr, dram_wdata,
    input  dram_ready, dram_rdata, dram_rvalid, dram_err
  );

  modport slave (
    input  dram_req, dram_write, dram_wstrb, dram_addr, dram_wdata,
    output dram_ready, dram_rdata, dram_rvalid, dram_err
  );
endinterface
`default_nettype wire

// File: rtl/dram_sram_resp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : dram_sram_resp
// Desc   : Data RAM responder over a word SRAM with programmable wait states;
//          DRAM_ADDR_CHECK_EN enables out-of-range detection.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module dram_sram_resp #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input wire logic        clk,
  input wire logic        rst_b,
  dram_sram_resp_if.slave dram
);
  localparam int unsigned c_AW   = $clog2(DEPTH);
  localparam logic [3:0]  c_WAIT = 4'(WAIT_CYCLES);

  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;
  logic            r_rvalid;
  logic            r_err;

  logic            w_ready;
  logic            w_hs;
  logic            w_in_range;
  logic [XLEN-1:0] w_off;
  logic [c_AW-1:0] w_idx;
  logic            w_unused;

  assign w_off    = dram.dram_addr - BASE_ADDR;
  assign w_idx    = w_off[c_AW+1:2];
  assign w_ready  = dram.dram_req && (r_cnt == c_WAIT);
  assign w_hs     = w_ready && rst_b;
  assign w_unused = ^{w_off[1:0], w_off[XLEN-1:c_AW+2]};

`ifdef DRAM_ADDR_CHECK_EN
  localparam logic [XLEN:0] c_SPAN = (XLEN+1)'(DEPTH) << 2;
  assign w_in_range = ({1'b0, w_off} < c_SPAN);
`else
  assign w_in_range = 1'b1;
`endif

  // Wait-state counter doubles as the IDLE/WAIT/DONE state.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_cnt <= 4'd0;
    end else if (!dram.dram_req || w_ready) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && dram.dram_write && w_in_range) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (dram.dram_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= dram.dram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_hs && !dram.dram_write;
      r_err    <= w_hs && !w_in_range;
      if (w_hs && !dram.dram_write) begin
        r_rdata <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  assign dram.dram_ready  = w_ready;
  assign dram.dram_rdata  = r_rdata;
  assign dram.dram_rvalid = r_rvalid;
  assign dram.dram_err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_dram_sram_resp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_dram_sram_resp
// Desc   : Two responders (0 and 3 wait states) against a word-array model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_dram_sram_resp;
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  dram_sram_resp_if if0 ();
  dram_sram_resp_if if3 ();

  dram_sram_resp #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst_b(rst_b), .dram(if0.slave));
  dram_sram_resp #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst_b(rst_b), .dram(if3.slave));

  int checks = 0;
  int passed = 0;
  int waits [2] = '{0, 3};
  logic [31:0] ref_mem [2][64];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input int d, input logic req, input logic wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      if0.dram_req = req; if0.dram_write = wr; if0.dram_wstrb = strb;
      if0.dram_addr = addr; if0.dram_wdata = wdata;
    end else begin
      if3.dram_req = req; if3.dram_write = wr; if3.dram_wstrb = strb;
      if3.dram_addr = addr; if3.dram_wdata = wdata;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? if0.dram_ready : if3.dram_ready;
  endfunction
  function automatic logic get_rvalid(input int d);
    return (d == 0) ? if0.dram_rvalid : if3.dram_rvalid;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? if0.dram_rdata : if3.dram_rdata;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? if0.dram_err : if3.dram_err;
  endfunction

  // Entered and left at negedge+1; n counts cycles with ready low before the handshake.
  task automatic handshake(input int d, input logic wr, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int n, output logic rv, output logic [31:0] rd,
                           output logic er);
    drive(d, 1'b1, wr, strb, addr, wdata);
    n = 0;
    #1;
    while (!get_ready(d) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    rv = get_rvalid(d);
    rd = get_rdata(d);
    er = get_err(d);
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    idle(0); idle(1);
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({get_ready(d), get_rvalid(d), get_err(d), get_rdata(d)} !== 35'h0)
        $display("FAIL reset d%0d: ready=%b rvalid=%b err=%b rdata=%h, want all 0",
                 d, get_ready(d), get_rvalid(d), get_err(d), get_rdata(d));
      else passed++;
    end
    rst_b = 1'b1;
  endtask

  task automatic test_preload();
    int n; logic rv, er; logic [31:0] rd, v;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) begin
        v = $urandom | 32'h0100_0000;
        handshake(d, 1'b1, 4'hF, 32'(w * 4), v, n, rv, rd, er);
        ref_mem[d][w] = v;
        checks++;
        if (n !== waits[d] || rv !== 1'b0)
          $display("FAIL preload d%0d w%0d: wait=%0d rvalid=%b, want wait=%0d rvalid=0",
                   d, w, n, rv, waits[d]);
        else passed++;
      end
      idle(d);
    end
  endtask

  task automatic test_basic();
    int n; logic rv, er; logic [31:0] rd;
    handshake(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, n, rv, rd, er);
    ref_mem[0][4] = 32'hDEAD_BEEF;
    checks++;
    if (n !== 0 || rv !== 1'b0) $display("FAIL basic_wr: wait=%0d rvalid=%b, want 0/0", n, rv);
    else passed++;
    handshake(0, 1'b0, 4'h0, 32'h10, 32'h0, n, rv, rd, er);
    checks++;
    if (n !== 0 || rv !== 1'b1 || rd !== 32'hDEAD_BEEF)
      $display("FAIL basic_rd: wait=%0d rvalid=%b rdata=%h, want 0/1/deadbeef", n, rv, rd);
    else passed++;
    idle(0);
  endtask

  task automatic test_strobe();
    int n; logic rv, er; logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      handshake(d, 1'b1, 4'hF, 32'h20, 32'h1122_3344, n, rv, rd, er);
      handshake(d, 1'b1, 4'b0100, 32'h20, 32'hAAAA_AAAA, n, rv, rd, er);
      handshake(d, 1'b0, 4'hF, 32'h22, 32'h0, n, rv, rd, er);
      ref_mem[d][8] = 32'h11AA_3344;
      checks++;
      if (rv !== 1'b1 || rd !== 32'h11AA_3344)
        $display("FAIL strobe d%0d: rvalid=%b rdata=%h, want 1/11aa3344", d, rv, rd);
      else passed++;
      idle(d);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic rv, er; logic [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      handshake(1, 1'b0, 4'h0, 32'h20, 32'h0, n, rv, rd, er);
      checks++;
      if (n !== 3 || rv !== 1'b1 || rd !== 32'h11AA_3344)
        $display("FAIL b2b_rd%0d: wait=%0d rvalid=%b rdata=%h, want 3/1/11aa3344", k, n, rv, rd);
      else passed++;
    end
    idle(1);
  endtask

  task automatic test_abort();
    int n; logic rv, er; logic [31:0] rd;
    @(negedge clk); #1;
    drive(1, 1'b1, 1'b1, 4'hF, 32'h14, ~ref_mem[1][5]);
    repeat (2) begin
      #1;
      checks++;
      if (get_ready(1) !== 1'b0) $display("FAIL abort_ready: ready=%b, want 0", get_ready(1));
      else passed++;
      @(negedge clk); #1;
    end
    idle(1);
    @(negedge clk); #1;
    checks++;
    if (get_rvalid(1) !== 1'b0 || get_ready(1) !== 1'b0)
      $display("FAIL abort_idle: rvalid=%b ready=%b, want 0/0", get_rvalid(1), get_ready(1));
    else passed++;
    handshake(1, 1'b0, 4'h0, 32'h14, 32'h0, n, rv, rd, er);
    checks++;
    if (n !== 3 || rv !== 1'b1 || rd !== ref_mem[1][5])
      $display("FAIL abort_rd: wait=%0d rvalid=%b rdata=%h, want 3/1/%h", n, rv, rd, ref_mem[1][5]);
    else passed++;
    idle(1);
  endtask

  task automatic test_reset_mid_wait();
    int n; logic rv, er; logic [31:0] rd;
    handshake(0, 1'b0, 4'h0, 32'h20, 32'h0, n, rv, rd, er);
    idle(0);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_b = 1'b0;
    idle(1);
    @(negedge clk); #1;
    rst_b = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get_rdata(d) !== 32'h0 || get_rvalid(d) !== 1'b0 || get_ready(d) !== 1'b0)
        $display("FAIL rst_mid d%0d: rdata=%h rvalid=%b ready=%b, want 0/0/0",
                 d, get_rdata(d), get_rvalid(d), get_ready(d));
      else passed++;
    end
    handshake(1, 1'b0, 4'h0, 32'h14, 32'h0, n, rv, rd, er);
    checks++;
    if (n !== 3 || rv !== 1'b1 || rd !== ref_mem[1][5])
      $display("FAIL rst_mid_rd: wait=%0d rvalid=%b rdata=%h, want 3/1/%h", n, rv, rd, ref_mem[1][5]);
    else passed++;
    idle(1);
  endtask

  task automatic test_random();
    int n, d, w, k; logic rv, er, wr; logic [31:0] rd, addr, data; logic [3:0] strb;
    for (int t = 0; t < 150; t++) begin
      d = $urandom_range(0, 1);
      w = $urandom_range(0, 63);
      addr = 32'(w * 4 + $urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      strb = 4'($urandom);
      data = $urandom;
      if (d == 1 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 3);
        drive(1, 1'b1, 1'b1, 4'hF, addr, ~data);
        repeat (k) @(negedge clk);
        #1;
        idle(1);
        @(negedge clk); #1;
        checks++;
        if (get_rvalid(1) !== 1'b0) $display("FAIL rnd_abort t%0d: rvalid=%b, want 0", t, get_rvalid(1));
        else passed++;
      end
      handshake(d, wr, strb, addr, data, n, rv, rd, er);
      if (wr) ref_mem[d][w] = merge(ref_mem[d][w], data, strb);
      checks++;
      if (n !== waits[d] || rv !== !wr || er !== 1'b0 || (!wr && rd !== ref_mem[d][w]))
        $display("FAIL rnd t%0d d%0d wr%0d a=%h: wait=%0d rvalid=%b err=%b rdata=%h, want %0d/%b/0/%h",
                 t, d, wr, addr, n, rv, er, rd, waits[d], !wr, ref_mem[d][w]);
      else passed++;
      idle(d);
    end
  endtask

  task automatic test_addr_range();
    int n; logic rv, er; logic [31:0] rd;
    handshake(0, 1'b1, 4'hF, 32'h0000_4000, 32'hCAFE_F00D, n, rv, rd, er);
`ifdef DRAM_ADDR_CHECK_EN
    checks++;
    if (n !== 0 || er !== 1'b1 || rv !== 1'b0)
      $display("FAIL oor_wr: wait=%0d err=%b rvalid=%b, want 0/1/0", n, er, rv);
    else passed++;
    handshake(0, 1'b0, 4'h0, 32'h0000_4000, 32'h0, n, rv, rd, er);
    checks++;
    if (n !== 0 || er !== 1'b1 || rv !== 1'b1 || rd !== 32'h0)
      $display("FAIL oor_rd: wait=%0d err=%b rvalid=%b rdata=%h, want 0/1/1/0", n, er, rv, rd);
    else passed++;
`else
    ref_mem[0][0] = 32'hCAFE_F00D;
    checks++;
    if (n !== 0 || er !== 1'b0)
      $display("FAIL wrap_wr: wait=%0d err=%b, want 0/0", n, er);
    else passed++;
    handshake(0, 1'b0, 4'h0, 32'h0000_4000, 32'h0, n, rv, rd, er);
    checks++;
    if (er !== 1'b0 || rv !== 1'b1 || rd !== 32'hCAFE_F00D)
      $display("FAIL wrap_rd: err=%b rvalid=%b rdata=%h, want 0/1/cafef00d", er, rv, rd);
    else passed++;
`endif
    handshake(0, 1'b0, 4'h0, 32'h0, 32'h0, n, rv, rd, er);
    checks++;
    if (er !== 1'b0 || rv !== 1'b1 || rd !== ref_mem[0][0])
      $display("FAIL word0: err=%b rvalid=%b rdata=%h, want 0/1/%h", er, rv, rd, ref_mem[0][0]);
    else passed++;
    idle(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(0); idle(1);
    rst_b = 1'b0;
    @(negedge clk); #1;
    test_reset();
    @(negedge clk); #1;
    test_preload();
    test_basic();
    test_strobe();
    test_back_to_back();
    test_abort();
    test_reset_mid_wait();
    test_random();
    test_addr_range();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dram_sram_resp.md
Name: dram_sram_resp

Overview:
- Responder (slave) end of the core's data RAM request interface (dram_req/write/wstrb/addr/wdata/ready).
- Backs a word-organised single-port SRAM array.
- Inserts a programmable number of wait states before asserting ready, applies byte strobes on writes, and returns registered read data one cycle after each read handshake.
- Used as the data memory in the core's simulation/FPGA top, paired with the execute stage as initiator.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- DEPTH, 4096, number of XLEN-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- WAIT_CYCLES, 0, wait states per request before ready; range 0..15.

Ports:
- clk  in  1  clock.
- rst_b  in  1  synchronous active-low reset.
- dram_req  in  1  request valid; held with stable attributes until ready, or withdrawn on pipeline flush.
- dram_write  in  1  1 = write, 0 = read.
- dram_wstrb  in  4  byte enables for writes; ignored on reads.
- dram_addr  in  32  byte address; bits [1:0] ignored for array indexing.
- dram_wdata  in  32  write data, already lane-replicated by the initiator.
- dram_ready  out  1  handshake complete this cycle (req & ready).
- dram_rdata  out  32  read data; valid the cycle after a read handshake, held until the next read handshake.
- dram_rvalid  out  1  one-cycle pulse, the cycle after a read handshake.
- dram_err  out  1  one-cycle pulse, the cycle after an out-of-range handshake (optional feature only).

Behaviour:
- Reset (rst_b=0 at posedge): wait counter=0, dram_rdata=0, dram_rvalid=0, dram_err=0. Array contents are not reset.
- Word index = (dram_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- Wait counter cnt is 4 bits.
  - dram_ready = dram_req & (cnt == WAIT_CYCLES). Combinational, so WAIT_CYCLES=0 gives a same-cycle handshake, i.e. zero stall.
  - Counter update priority: if !dram_req, cnt<=0; else if dram_ready, cnt<=0; else cnt<=cnt+1.
- FSM (implicit in cnt):
  - IDLE: cnt==0, no req.
  - WAIT: req held, cnt<WAIT_CYCLES.
  - DONE: ready cycle, then return to IDLE.
  - Back-to-back requests: a new request starting the cycle after a handshake sees cnt=0 and waits the full WAIT_CYCLES again.
- Abort: dram_req dropping before ready (pipeline flush) discards the request. No write occurs, no rvalid is produced, cnt returns to 0.
- Write handshake: at the posedge, mem[idx] byte i <= wdata byte i for each wstrb[i]=1. wstrb=0 is a legal no-op that still handshakes.
- Read handshake: at the posedge, dram_rdata <= mem[idx] and dram_rvalid <= 1. In all other cycles dram_rvalid <= 0 and dram_rdata holds.
- Read-after-write to the same word in consecutive handshakes returns the newly written data.
- Attribute changes while in WAIT are not checked; the values sampled in the ready cycle are used.
- Reset mid-WAIT: cnt cleared and the request is lost; the initiator re-presents it after reset.

Optional Feature:
- DRAM_ADDR_CHECK_EN defined:
  - A handshake whose address lies outside [BASE_ADDR, BASE_ADDR+DEPTH*4) still completes normally (ready timing unchanged).
  - Writes are suppressed.
  - Reads return dram_rdata=0 with dram_rvalid=1.
  - dram_err pulses for 1 cycle after the handshake.
- DRAM_ADDR_CHECK_EN undefined: address wraps modulo DEPTH words; dram_err is tied 0.

Test Plan:
1. WAIT_CYCLES=0: write addr 0x10, wstrb 4'hF, wdata 0xDEADBEEF, then read 0x10 -> ready the same cycle as each req; next cycle rvalid=1, rdata=0xDEADBEEF.
2. Byte strobes: word 0x20 = 0x11223344; write wstrb 4'b0100, wdata 0xAAAAAAAA; read 0x22 -> rdata=0x11AA3344.
3. WAIT_CYCLES=3: hold read req -> ready asserted exactly 4th cycle of req (cycles 0,1,2 low); immediate second req -> ready again after 3 wait cycles.
4. WAIT_CYCLES=3: write req dropped after 2 cycles (flush), then read the same word -> old data returned, no rvalid during abort, cnt restarts from 0.
5. Reset asserted mid-WAIT, then released -> rdata=0, rvalid=0, ready=0 until a fresh req completes the full wait count.
6. DRAM_ADDR_CHECK_EN, DEPTH=4096, BASE 0: write 0x0000_4000 then read 0x0000_4000 -> both handshake, err pulses twice, read rdata=0; word 0 unchanged.
